itype_exec_unit: RTL and testbench



---
 rtl/itype_pkg.sv | 57 +++++
 rtl/itype_regfile.sv | 36 +++
 rtl/itype_exec_unit.sv | 136 +++++++++++++
 tb/tb_itype_exec_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/itype_pkg.sv
// -----------------------------------------------------------------------------
// itype_pkg
// Shared types and helpers for the I-type execute/writeback slice.
//   XLEN, NREGS, REG_AW : datapath width, register count, register index width
//   alu_op_t            : internal op encoding derived from decoder enables
//   onehot_to_op()      : one-hot enables -> op plus malformed-enable flag
//   sext12()            : 12-bit immediate sign extension to XLEN
// -----------------------------------------------------------------------------
package itype_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADDI = 3'd1,
    OP_XORI = 3'd2,
    OP_ORI  = 3'd3,
    OP_ANDI = 3'd4,
    OP_SLLI = 3'd5,
    OP_SRLI = 3'd6,
    OP_SRAI = 3'd7
  } alu_op_t;

  typedef struct packed {
    alu_op_t op;
    logic    illegal;
  } op_dec_t;

  // en bit order: {srai, srli, slli, andi, ori, xori, addi}.
  // All-zero is a bubble (not illegal); two or more set bits is illegal.
  function automatic op_dec_t onehot_to_op(input logic [6:0] en);
    op_dec_t d;
    d.illegal = 1'b0;
    case (en)
      7'b0000000: d.op = OP_NONE;
      7'b0000001: d.op = OP_ADDI;
      7'b0000010: d.op = OP_XORI;
      7'b0000100: d.op = OP_ORI;
      7'b0001000: d.op = OP_ANDI;
      7'b0010000: d.op = OP_SLLI;
      7'b0100000: d.op = OP_SRLI;
      7'b1000000: d.op = OP_SRAI;
      default: begin
        d.op      = OP_NONE;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/itype_regfile.sv
// -----------------------------------------------------------------------------
// itype_regfile
// NREGS x XLEN integer register file, x0 hardwired to zero.
//   clk, reset        : clock, synchronous active-high clear of all entries
//   raddr_i / rdata_o : combinational read port (x0 reads zero)
//   we_i, waddr_i,
//   wdata_i           : synchronous write port (writes to x0 are dropped)
// -----------------------------------------------------------------------------
module itype_regfile
  import itype_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr_i,
  output logic [XLEN-1:0]   rdata_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] mem_q [NREGS];

  // Storage update: reset clears every entry and takes priority over a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i == '0) ? '0 : mem_q[raddr_i];

endmodule

// File: rtl/itype_exec_unit.sv
// -----------------------------------------------------------------------------
// itype_exec_unit
// Two-stage execute/writeback for ADDI/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
//   clk, reset        : clock, synchronous active-high reset
//   *_en              : one-hot op select from the decoder
//   rs1, rd, imm      : source index, destination index, raw 12-bit immediate
//   rd_en, wr_en      : instruction valid, instruction writes rd
//   alu_result, result_valid, result_rd : registered E2 result
//   illegal_op        : one-cycle pulse for malformed (multi-hot) enables
// Build option: ITYPE_EXEC_FWD_EN enables E1/E2 -> operand A forwarding;
// without it operand A comes from the register file only.
// -----------------------------------------------------------------------------
module itype_exec_unit
  import itype_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              addi_en,
  input  logic              xori_en,
  input  logic              ori_en,
  input  logic              andi_en,
  input  logic              slli_en,
  input  logic              srli_en,
  input  logic              srai_en,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rd,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [11:0]       imm,
  output logic [XLEN-1:0]   alu_result,
  output logic              result_valid,
  output logic [REG_AW-1:0] result_rd,
  output logic              illegal_op
);

  op_dec_t         dec_s;
  logic            accept_s;
  logic [XLEN-1:0] rf_rdata_s;
  logic [XLEN-1:0] opa_d;
  logic [XLEN-1:0] alu_out_s;

  // E1 stage
  logic              e1_valid_q;
  alu_op_t           e1_op_q;
  logic [XLEN-1:0]   e1_a_q;
  logic [XLEN-1:0]   e1_imm_q;
  logic [REG_AW-1:0] e1_rd_q;
  logic              e1_wr_q;

  // E2 stage
  logic [XLEN-1:0]   e2_result_q;
  logic              e2_valid_q;
  logic [REG_AW-1:0] e2_rd_q;
  logic              e2_wr_q;
  logic              illegal_q;

  assign dec_s    = onehot_to_op({srai_en, srli_en, slli_en, andi_en,
                                  ori_en, xori_en, addi_en});
  assign accept_s = rd_en && !dec_s.illegal && (dec_s.op != OP_NONE);

  itype_regfile u_rf (
    .clk     (clk),
    .reset   (reset),
    .raddr_i (rs1),
    .rdata_o (rf_rdata_s),
    .we_i    (e2_valid_q && e2_wr_q),
    .waddr_i (e2_rd_q),
    .wdata_i (e2_result_q)
  );

  // Operand A select: x0, then youngest in-flight producer, then RF.
  always_comb begin
    opa_d = rf_rdata_s;
    if (rs1 == '0) begin
      opa_d = '0;
`ifdef ITYPE_EXEC_FWD_EN
    end else if (e1_valid_q && e1_wr_q && (e1_rd_q == rs1)) begin
      opa_d = alu_out_s;
    end else if (e2_valid_q && e2_wr_q && (e2_rd_q == rs1)) begin
      opa_d = e2_result_q;
`endif
    end else begin
      opa_d = rf_rdata_s;
    end
  end

  // E1 ALU; shifts use only imm[4:0].
  always_comb begin
    alu_out_s = '0;
    case (e1_op_q)
      OP_ADDI: alu_out_s = e1_a_q + e1_imm_q;
      OP_XORI: alu_out_s = e1_a_q ^ e1_imm_q;
      OP_ORI:  alu_out_s = e1_a_q | e1_imm_q;
      OP_ANDI: alu_out_s = e1_a_q & e1_imm_q;
      OP_SLLI: alu_out_s = e1_a_q << e1_imm_q[4:0];
      OP_SRLI: alu_out_s = e1_a_q >> e1_imm_q[4:0];
      OP_SRAI: alu_out_s = $unsigned($signed(e1_a_q) >>> e1_imm_q[4:0]);
      default: alu_out_s = '0;
    endcase
  end

  // Pipeline registers; reset discards in-flight ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      e1_valid_q  <= 1'b0;
      e1_op_q     <= OP_NONE;
      e1_a_q      <= '0;
      e1_imm_q    <= '0;
      e1_rd_q     <= '0;
      e1_wr_q     <= 1'b0;
      e2_result_q <= '0;
      e2_valid_q  <= 1'b0;
      e2_rd_q     <= '0;
      e2_wr_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      e1_valid_q  <= accept_s;
      e1_op_q     <= accept_s ? dec_s.op : OP_NONE;
      e1_a_q      <= opa_d;
      e1_imm_q    <= sext12(imm);
      e1_rd_q     <= rd;
      e1_wr_q     <= accept_s && wr_en;
      e2_result_q <= e1_valid_q ? alu_out_s : '0;
      e2_valid_q  <= e1_valid_q;
      e2_rd_q     <= e1_valid_q ? e1_rd_q : '0;
      e2_wr_q     <= e1_valid_q && e1_wr_q;
      illegal_q   <= rd_en && dec_s.illegal;
    end
  end

  assign alu_result   = e2_result_q;
  assign result_valid = e2_valid_q;
  assign result_rd    = e2_rd_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_itype_exec_unit.sv
module tb_itype_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        addi_en, xori_en, ori_en, andi_en, slli_en, srli_en, srai_en;
  logic [4:0]  rs1, rd;
  logic        rd_en, wr_en;
  logic [11:0] imm;
  logic [31:0] alu_result;
  logic        result_valid;
  logic [4:0]  result_rd;
  logic        illegal_op;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [6:0] ADDI = 7'b0000001;
  localparam logic [6:0] XORI = 7'b0000010;
  localparam logic [6:0] ORI  = 7'b0000100;
  localparam logic [6:0] ANDI = 7'b0001000;
  localparam logic [6:0] SLLI = 7'b0010000;
  localparam logic [6:0] SRLI = 7'b0100000;
  localparam logic [6:0] SRAI = 7'b1000000;

  always #5 clk = ~clk;

  itype_exec_unit dut (
    .clk(clk), .reset(reset),
    .addi_en(addi_en), .xori_en(xori_en), .ori_en(ori_en), .andi_en(andi_en),
    .slli_en(slli_en), .srli_en(srli_en), .srai_en(srai_en),
    .rs1(rs1), .rd(rd), .rd_en(rd_en), .wr_en(wr_en), .imm(imm),
    .alu_result(alu_result), .result_valid(result_valid),
    .result_rd(result_rd), .illegal_op(illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] en, input logic [4:0] d, input logic [4:0] s,
                       input logic [11:0] im, input logic v, input logic w);
    {srai_en, srli_en, slli_en, andi_en, ori_en, xori_en, addi_en} = en;
    rd = d; rs1 = s; imm = im; rd_en = v; wr_en = w;
  endtask

  task automatic issue(input logic [6:0] en, input logic [4:0] d, input logic [4:0] s,
                       input logic [11:0] im);
    drive(en, d, s, im, 1'b1, 1'b1);
    step();
  endtask

  task automatic bubble();
    drive(7'b0000000, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0);
    step();
  endtask

  task automatic do_reset();
    bubble();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(7'b0000000, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    check("rst_result", alu_result, 32'h0);
    check("rst_valid", {31'd0, result_valid}, 32'h0);
    check("rst_rd", {27'd0, result_rd}, 32'h0);
    check("rst_illegal", {31'd0, illegal_op}, 32'h0);

    // Basic ADDI latency and writeback
    issue(ADDI, 5'd9, 5'd7, 12'h304);
    bubble();
    check("addi_result", alu_result, 32'h00000304);
    check("addi_rd", {27'd0, result_rd}, 32'd9);
    check("addi_valid", {31'd0, result_valid}, 32'd1);
    bubble();
    check("addi_valid_drop", {31'd0, result_valid}, 32'd0);
    issue(ADDI, 5'd10, 5'd9, 12'h000);
    bubble();
    check("rf9_readback", alu_result, 32'h00000304);

    // Back-to-back dependents (E1 then E2 forwarding)
    do_reset();
    issue(ADDI, 5'd9, 5'd0, 12'h304);
    issue(ADDI, 5'd13, 5'd9, 12'h001);
    check("b2b_a", alu_result, 32'h00000304);
    issue(ADDI, 5'd14, 5'd9, 12'h002);
`ifdef ITYPE_EXEC_FWD_EN
    check("b2b_e1fwd", alu_result, 32'h00000305);
`else
    check("b2b_e1fwd", alu_result, 32'h00000001);
`endif
    check("b2b_e1fwd_rd", {27'd0, result_rd}, 32'd13);
    bubble();
`ifdef ITYPE_EXEC_FWD_EN
    check("b2b_e2fwd", alu_result, 32'h00000306);
`else
    check("b2b_e2fwd", alu_result, 32'h00000002);
`endif
    bubble();
    bubble();

    // Sign extension and shifts (dependents spaced by 2 bubbles)
    issue(ADDI, 5'd1, 5'd0, 12'h800);
    bubble();
    check("addi_neg", alu_result, 32'hFFFFF800);
    bubble();
    issue(SRAI, 5'd2, 5'd1, 12'h404);
    issue(SRLI, 5'd3, 5'd1, 12'h004);
    check("srai", alu_result, 32'hFFFFFF80);
    issue(SLLI, 5'd4, 5'd1, 12'h004);
    check("srli", alu_result, 32'h0FFFFF80);
    issue(XORI, 5'd5, 5'd1, 12'h0FF);
    check("slli", alu_result, 32'hFFFF8000);
    issue(ORI, 5'd5, 5'd1, 12'h7FF);
    check("xori", alu_result, 32'hFFFFF8FF);
    issue(ANDI, 5'd6, 5'd9, 12'h1FC);
    check("ori", alu_result, 32'hFFFFFFFF);
    issue(ADDI, 5'd7, 5'd1, 12'h800);
    check("andi", alu_result, 32'h00000104);
    bubble();
    check("addi_wrap", alu_result, 32'hFFFFF000);

    // x0 destination is never written
    issue(ADDI, 5'd0, 5'd0, 12'h005);
    issue(ADDI, 5'd5, 5'd0, 12'h000);
    check("x0_wr_result", alu_result, 32'h00000005);
    check("x0_wr_valid", {31'd0, result_valid}, 32'd1);
    bubble();
    check("x0_read", alu_result, 32'h00000000);
    check("x0_read_rd", {27'd0, result_rd}, 32'd5);
    bubble();

    // Malformed enables and zero enables
    drive(ADDI | ORI, 5'd9, 5'd0, 12'h007, 1'b1, 1'b1);
    step();
    check("illegal_pulse", {31'd0, illegal_op}, 32'd1);
    check("illegal_valid", {31'd0, result_valid}, 32'd0);
    bubble();
    check("illegal_end", {31'd0, illegal_op}, 32'd0);
    check("illegal_no_res", {31'd0, result_valid}, 32'd0);
    drive(7'b0000000, 5'd9, 5'd0, 12'h678, 1'b1, 1'b1);
    step();
    check("noen_illegal", {31'd0, illegal_op}, 32'd0);
    bubble();
    check("noen_valid", {31'd0, result_valid}, 32'd0);
    bubble();
    bubble();
    issue(ADDI, 5'd11, 5'd9, 12'h000);
    bubble();
    check("rf9_unchanged", alu_result, 32'h00000304);
    bubble();

    // Reset while an op is in flight
    issue(ANDI, 5'd6, 5'd0, 12'h0FF);
    reset = 1'b1;
    drive(7'b0000000, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    check("midrst_valid", {31'd0, result_valid}, 32'd0);
    check("midrst_result", alu_result, 32'h0);
    check("midrst_rd", {27'd0, result_rd}, 32'd0);
    bubble();
    check("midrst_valid2", {31'd0, result_valid}, 32'd0);
    bubble();
    issue(ADDI, 5'd12, 5'd6, 12'h000);
    bubble();
    check("midrst_rf6", alu_result, 32'h00000000);
    issue(ADDI, 5'd12, 5'd9, 12'h000);
    bubble();
    check("rst_rf9_cleared", alu_result, 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
